// File: rtl/count_fecha.sv
// Day/month calendar counter: run mode advances on tickF, edit mode steps the selected field.
// Optional macro COUNT_FECHA_LEAP_EN enables 29-day February in leap years (yearF[1:0]==0).
module count_fecha (
    input  logic       clkF,
    input  logic       resetF,
    input  logic       tickF,
    input  logic       enF,
    input  logic       selF,
    input  logic       upF,
    input  logic       downF,
    input  logic [6:0] yearF,
    output logic [4:0] diaF,
    output logic [3:0] mesF,
    output logic       carry_upF
);

    logic [4:0] r_dia;
    logic [3:0] r_mes;
    logic       r_carry;

    logic       w_leap;
    logic [4:0] w_dim;
    logic       w_dia_bad;
    logic       w_mes_bad;
    logic       w_edit_step;

`ifdef COUNT_FECHA_LEAP_EN
    assign w_leap = (yearF[1:0] == 2'b00);
`else
    // February fixed at 28 days; the year input is deliberately left dangling.
    logic w_unused_year;
    assign w_unused_year = ^yearF;
    assign w_leap        = 1'b0;
`endif

    always_comb begin
        w_dim = 5'd31;
        case (r_mes)
            4'd4, 4'd6, 4'd9, 4'd11: w_dim = 5'd30;
            4'd2:                    w_dim = w_leap ? 5'd29 : 5'd28;
            default:                 w_dim = 5'd31;
        endcase
    end

    assign w_dia_bad   = (r_dia == 5'd0);
    assign w_mes_bad   = (r_mes == 4'd0) || (r_mes > 4'd12);
    assign w_edit_step = enF && (upF || downF);

    always_ff @(posedge clkF) begin
        if (!resetF) begin
            r_dia   <= 5'd1;
            r_mes   <= 4'd1;
            r_carry <= 1'b0;
        end else begin
            r_carry <= 1'b0;
            if (w_dia_bad || w_mes_bad) begin
                if (w_dia_bad) r_dia <= 5'd1;
                if (w_mes_bad) r_mes <= 4'd1;
            end else if (!enF && tickF) begin
                // A day beyond the month length (pending clamp) also counts as end of month.
                if (r_dia >= w_dim) begin
                    r_dia <= 5'd1;
                    if (r_mes >= 4'd12) begin
                        r_mes   <= 4'd1;
                        r_carry <= 1'b1;
                    end else begin
                        r_mes <= r_mes + 4'd1;
                    end
                end else begin
                    r_dia <= r_dia + 5'd1;
                end
            end else if (w_edit_step && !selF) begin
                if (upF)
                    r_dia <= (r_dia >= w_dim) ? 5'd1 : r_dia + 5'd1;
                else if (r_dia == 5'd1)
                    r_dia <= w_dim;
                else if (r_dia > w_dim)
                    r_dia <= w_dim;
                else
                    r_dia <= r_dia - 5'd1;
            end else if (w_edit_step) begin
                // Month edits leave the day alone; any clamp lands on the next cycle.
                if (upF)
                    r_mes <= (r_mes >= 4'd12) ? 4'd1 : r_mes + 4'd1;
                else
                    r_mes <= (r_mes == 4'd1) ? 4'd12 : r_mes - 4'd1;
            end else if (r_dia > w_dim) begin
                r_dia <= w_dim;
            end
        end
    end

    assign diaF      = r_dia;
    assign mesF      = r_mes;
    assign carry_upF = r_carry;

endmodule

// File: tb/tb_count_fecha.sv
// Self-checking bench for count_fecha: a directed vector table plus hand sequences for
// rollover, leap February, clamp and edit corner cases.
module tb_count_fecha;

    logic       clkF = 1'b0;
    logic       resetF, tickF, enF, selF, upF, downF;
    logic [6:0] yearF;
    logic [4:0] diaF;
    logic [3:0] mesF;
    logic       carry_upF;

    int checks   = 0;
    int failures = 0;

    count_fecha dut (
        .clkF      (clkF),
        .resetF    (resetF),
        .tickF     (tickF),
        .enF       (enF),
        .selF      (selF),
        .upF       (upF),
        .downF     (downF),
        .yearF     (yearF),
        .diaF      (diaF),
        .mesF      (mesF),
        .carry_upF (carry_upF)
    );

    always #5 clkF = ~clkF;

    typedef struct {
        string      name;
        logic       rst_n, en, sel, up, down, tick;
        logic [4:0] exp_dia;
        logic [3:0] exp_mes;
        logic       exp_carry;
    } vec_t;

    function automatic int feb_days(input int yr);
`ifdef COUNT_FECHA_LEAP_EN
        return (yr % 4 == 0) ? 29 : 28;
`else
        return 28;
`endif
    endfunction

    task automatic drive(input logic rst_n, input logic en, input logic sel,
                         input logic up, input logic down, input logic tick);
        resetF = rst_n; enF = en; selF = sel; upF = up; downF = down; tickF = tick;
        @(posedge clkF);
        #1;
        resetF = 1'b1; enF = 1'b0; selF = 1'b0; upF = 1'b0; downF = 1'b0; tickF = 1'b0;
    endtask

    task automatic check(input string name, input int e_dia, input int e_mes, input int e_carry);
        checks++;
        if (diaF !== 5'(e_dia) || mesF !== 4'(e_mes) || carry_upF !== 1'(e_carry)) begin
            failures++;
            $display("FAIL %s: got dia=%0d mes=%0d carry=%0d, expected dia=%0d mes=%0d carry=%0d",
                     name, diaF, mesF, carry_upF, e_dia, e_mes, e_carry);
        end else begin
            $display("ok   %s: dia=%0d mes=%0d carry=%0d", name, diaF, mesF, carry_upF);
        end
    endtask

    // Reset, then walk the month and day up from 1/1 using edit mode.
    task automatic set_date(input int d, input int m);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < m; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < d; i++) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    vec_t vecs[18];

    initial begin
        resetF = 1'b1; tickF = 1'b0; enF = 1'b0; selF = 1'b0; upF = 1'b0; downF = 1'b0;
        yearF  = 7'd1;

        //          name            rst en sel up dn tk   dia mes carry
        vecs[0]  = '{"reset_over",  0, 0, 0, 1, 0, 1,  1,  1, 0};
        vecs[1]  = '{"tick_2",      1, 0, 0, 0, 0, 1,  2,  1, 0};
        vecs[2]  = '{"tick_3",      1, 0, 0, 0, 0, 1,  3,  1, 0};
        vecs[3]  = '{"dn_day_2",    1, 1, 0, 0, 1, 0,  2,  1, 0};
        vecs[4]  = '{"dn_day_1",    1, 1, 0, 0, 1, 0,  1,  1, 0};
        vecs[5]  = '{"dn_wrap_31",  1, 1, 0, 0, 1, 0, 31,  1, 0};
        vecs[6]  = '{"edit_tick",   1, 1, 0, 0, 0, 1, 31,  1, 0};
        vecs[7]  = '{"end_jan",     1, 0, 0, 0, 0, 1,  1,  2, 0};
        vecs[8]  = '{"dn_mes_1",    1, 1, 1, 0, 1, 0,  1,  1, 0};
        vecs[9]  = '{"dn_mes_12",   1, 1, 1, 0, 1, 0,  1, 12, 0};
        vecs[10] = '{"dn_dec_31",   1, 1, 0, 0, 1, 0, 31, 12, 0};
        vecs[11] = '{"new_year",    1, 0, 0, 0, 0, 1,  1,  1, 1};
        vecs[12] = '{"carry_drop",  1, 0, 0, 0, 0, 0,  1,  1, 0};
        vecs[13] = '{"updn_mes",    1, 1, 1, 1, 1, 0,  1,  2, 0};
        vecs[14] = '{"dn_feb_28",   1, 1, 0, 0, 1, 0, 28,  2, 0};
        vecs[15] = '{"end_feb",     1, 0, 0, 0, 0, 1,  1,  3, 0};
        vecs[16] = '{"up_day_2",    1, 1, 0, 1, 0, 0,  2,  3, 0};
        vecs[17] = '{"reset_edit",  0, 1, 0, 1, 0, 1,  1,  1, 0};

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].rst_n, vecs[i].en, vecs[i].sel, vecs[i].up, vecs[i].down, vecs[i].tick);
            check(vecs[i].name, vecs[i].exp_dia, vecs[i].exp_mes, vecs[i].exp_carry);
        end

        // Year rollover: carry for exactly one cycle.
        yearF = 7'd23;
        set_date(31, 12);
        check("set_31_12", 31, 12, 0);
        drive(1'b1, 1'b0, 0, 0, 0, 1'b1);
        check("roll_pulse", 1, 1, 1);
        drive(1'b1, 1'b0, 0, 0, 0, 1'b0);
        check("roll_after", 1, 1, 0);

        // Reset coinciding with the rollover tick cancels the carry.
        set_date(31, 12);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b1);
        check("roll_reset", 1, 1, 0);

        // Reset during the carry pulse cycle.
        set_date(31, 12);
        drive(1'b1, 1'b0, 0, 0, 0, 1'b1);
        check("roll_pulse2", 1, 1, 1);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b1);
        check("reset_in_pulse", 1, 1, 0);

        // February with leap year 24 and non-leap year 23.
        yearF = 7'd24;
        set_date(28, 2);
        drive(1'b1, 1'b0, 0, 0, 0, 1'b1);
        if (feb_days(24) == 29) begin
            check("leap_28_29", 29, 2, 0);
            drive(1'b1, 1'b0, 0, 0, 0, 1'b1);
            check("leap_29_mar", 1, 3, 0);
        end else begin
            check("noleap_24_mar", 1, 3, 0);
        end
        yearF = 7'd23;
        set_date(28, 2);
        drive(1'b1, 1'b0, 0, 0, 0, 1'b1);
        check("y23_28_mar", 1, 3, 0);

        // Clamp after a month edit lands one cycle later.
        for (int yr = 23; yr <= 24; yr++) begin
            yearF = 7'(yr);
            set_date(31, 1);
            drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            check($sformatf("clamp_mes_y%0d", yr), 31, 2, 0);
            drive(1'b1, 1'b0, 0, 0, 0, 1'b0);
            check($sformatf("clamp_dia_y%0d", yr), feb_days(yr), 2, 0);
        end

        // Clamp on a year change with Feb 29 (reached via Jan 29 + month edit).
        yearF = 7'd24;
        set_date(29, 1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("feb29_edit", 29, 2, 0);
        drive(1'b1, 1'b0, 0, 0, 0, 1'b0);
        check("feb29_y24", feb_days(24), 2, 0);
        yearF = 7'd25;
        drive(1'b1, 1'b0, 0, 0, 0, 1'b0);
        check("feb_y25", 28, 2, 0);

        // Edit wrap, priority and tick ignored in edit mode.
        set_date(1, 4);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("apr_dn_wrap", 30, 4, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("apr_up_prio", 1, 4, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("apr_edit_tick", 1, 4, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("edit_hold", 1, 4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
